// File: rtl/sprite_row_reader.sv
// Fetches a run of mirrored sprite bytes from a synchronous ROM and streams
// the un-mirrored pixels left to right over a valid/ready handshake.
module sprite_row_reader #(
   parameter int ADDR_W = 12,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  nbytes,
   output logic              busy,
   output logic              rom_en,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [7:0]        rom_data,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic              pix_data,
   output logic              pix_attr,
   output logic              pix_last,
   output logic              done
);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      CAPTURE,
      SHIFT,
      FIN
   } state_t;

   localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
   localparam logic [CNT_W-1:0]  CNT_ONE  = 1;

   state_t            state;
   logic [ADDR_W-1:0] addr;
   logic [CNT_W-1:0]  remaining;
   logic [6:0]        px;
   logic [2:0]        index;
   logic [6:0]        unmirrored;

   // Stored bit 6-k holds pixel k; bit 7 is the attribute and stays put.
   always_comb begin
      unmirrored = '0;
      for (int k = 0; k < 7; k++) begin
         unmirrored[k] = rom_data[6-k];
      end
   end

   // Outputs are loaded on the transition into a state so they are valid for
   // exactly the cycles that state is occupied.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         addr      <= '0;
         remaining <= '0;
         px        <= '0;
         index     <= '0;
         busy      <= 1'b0;
         rom_en    <= 1'b0;
         rom_addr  <= '0;
         pix_valid <= 1'b0;
         pix_data  <= 1'b0;
         pix_attr  <= 1'b0;
         pix_last  <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               busy <= 1'b0;
               if (start) begin
                  busy <= 1'b1;
                  if (nbytes != '0) begin
                     addr      <= base_addr;
                     remaining <= nbytes;
                     rom_en    <= 1'b1;
                     rom_addr  <= base_addr;
                     state     <= FETCH;
                  end else begin
                     done  <= 1'b1;
                     state <= FIN;
                  end
               end
            end
            FETCH: begin
               rom_en <= 1'b0;
               state  <= CAPTURE;
            end
            CAPTURE: begin
               px        <= unmirrored;
               index     <= 3'd0;
               addr      <= addr + ADDR_ONE;
               remaining <= remaining - CNT_ONE;
               pix_valid <= 1'b1;
               pix_data  <= unmirrored[0];
               pix_attr  <= rom_data[7];
               pix_last  <= 1'b0;
               state     <= SHIFT;
            end
            SHIFT: begin
               if (pix_valid && pix_ready) begin
                  if (index != 3'd6) begin
                     index    <= index + 3'd1;
                     pix_data <= px[index + 3'd1];
                     pix_last <= (index == 3'd5) && (remaining == '0);
                  end else begin
                     pix_valid <= 1'b0;
                     pix_data  <= 1'b0;
                     pix_attr  <= 1'b0;
                     pix_last  <= 1'b0;
                     if (remaining != '0) begin
                        rom_en   <= 1'b1;
                        rom_addr <= addr;
                        state    <= FETCH;
                     end else begin
                        done  <= 1'b1;
                        state <= FIN;
                     end
                  end
               end
            end
            FIN: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
